// File: rtl/commit_checker_pkg.sv
// Shared constants and FSM encoding for the commit-stream checker.
package commit_checker_pkg;

    localparam int PC_WIDTH = 32;

    typedef enum logic [2:0] {
        CHK_IDLE = 3'd0,
        CHK_RUN  = 3'd1,
        CHK_PASS = 3'd2,
        CHK_FAIL = 3'd3,
        CHK_HANG = 3'd4
    } chk_state_e;

endpackage

// File: rtl/commit_trace_buf.sv
// Circular trace of retired PCs; read index 0 is the most recent push.
module commit_trace_buf #(
    parameter int TRACE_DEPTH = 16,
    parameter int PC_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [PC_WIDTH-1:0]            push_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic [PC_WIDTH-1:0]            rd_pc,
    output logic [$clog2(TRACE_DEPTH):0]   count
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic [PC_WIDTH-1:0] mem [TRACE_DEPTH];
    logic [IDX_W-1:0]    wr_ptr;
    logic [IDX_W-1:0]    rd_addr;

    // Storage is deliberately left unreset; count tells which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count != (IDX_W+1)'(TRACE_DEPTH)) begin
                count <= count + (IDX_W+1)'(1);
            end
        end
    end

    // Power-of-2 depth makes the subtraction wrap modulo the depth for free.
    assign rd_addr = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_pc   = mem[rd_addr];

endmodule

// File: rtl/commit_checker.sv
// Observes the CPU retirement stream, checks PC-chain consistency and
// flags halt-loop completion, chain breaks and retirement hangs.
module commit_checker
    import commit_checker_pkg::*;
#(
    parameter int TIMEOUT     = 1024,
    parameter int HALT_REPEAT = 4,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commit,
    input  logic [PC_WIDTH-1:0]            commit_pc,
    input  logic [PC_WIDTH-1:0]            commit_pre_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [2:0]                     state_o,
    output logic                           done,
    output logic                           pass,
    output logic [PC_WIDTH-1:0]            fail_pc,
    output logic [PC_WIDTH-1:0]            fail_exp_pc,
    output logic [31:0]                    commit_cnt,
    output logic [PC_WIDTH-1:0]            trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int HALT_W = $clog2(HALT_REPEAT + 1);

    chk_state_e          state, state_next;
    logic [PC_WIDTH-1:0] expected, expected_next;
    logic [HALT_W-1:0]   halt_cnt, halt_next, halt_inc;
    logic [IDLE_W-1:0]   idle_cnt, idle_next, idle_inc;
    logic [31:0]         cnt_next;
    logic [PC_WIDTH-1:0] fail_pc_next, fail_exp_next;
    logic                accept;

    assign accept   = commit && ((state == CHK_IDLE) || (state == CHK_RUN));
    assign halt_inc = halt_cnt + HALT_W'(1);
    assign idle_inc = idle_cnt + IDLE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CHK_IDLE;
            expected    <= '0;
            halt_cnt    <= '0;
            idle_cnt    <= '0;
            commit_cnt  <= '0;
            fail_pc     <= '0;
            fail_exp_pc <= '0;
        end else begin
            state       <= state_next;
            expected    <= expected_next;
            halt_cnt    <= halt_next;
            idle_cnt    <= idle_next;
            commit_cnt  <= cnt_next;
            fail_pc     <= fail_pc_next;
            fail_exp_pc <= fail_exp_next;
        end
    end

    // Terminal states fall through to the defaults, so everything freezes there.
    always_comb begin
        state_next    = state;
        expected_next = expected;
        halt_next     = halt_cnt;
        idle_next     = idle_cnt;
        cnt_next      = commit_cnt;
        fail_pc_next  = fail_pc;
        fail_exp_next = fail_exp_pc;

        case (state)
            CHK_IDLE, CHK_RUN: begin
                if (accept) begin
                    idle_next = '0;
                    if (commit_cnt != '1) begin
                        cnt_next = commit_cnt + 32'd1;
                    end
                    if (state == CHK_IDLE) begin
                        expected_next = commit_pre_pc;
                        state_next    = CHK_RUN;
                    end else if (commit_pc != expected) begin
                        state_next    = CHK_FAIL;
                        fail_pc_next  = commit_pc;
                        fail_exp_next = expected;
                    end else begin
                        expected_next = commit_pre_pc;
                        if (commit_pc == commit_pre_pc) begin
                            halt_next = halt_inc;
                            if (halt_inc == HALT_W'(HALT_REPEAT)) begin
                                state_next = CHK_PASS;
                            end
                        end else begin
                            halt_next = '0;
                        end
                    end
                end else begin
                    idle_next = idle_inc;
                    if (idle_inc == IDLE_W'(TIMEOUT)) begin
                        state_next = CHK_HANG;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign state_o = state;
    assign done    = (state == CHK_PASS) || (state == CHK_FAIL) || (state == CHK_HANG);
    assign pass    = (state == CHK_PASS);

    commit_trace_buf #(
        .TRACE_DEPTH(TRACE_DEPTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_trace (
        .clk    (clk),
        .rst    (rst),
        .push   (accept && !rst),
        .push_pc(commit_pc),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc),
        .count  (trace_cnt)
    );

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench for commit_checker: directed test-plan scenarios followed by
// randomized commit streams, checked against a queue-based reference model.
module tb_commit_checker;

    localparam int TIMEOUT     = 8;
    localparam int HALT_REPEAT = 4;
    localparam int TRACE_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_pre_pc = '0;
    logic [1:0]  trace_idx = '0;
    logic [2:0]  state_o;
    logic        done;
    logic        pass;
    logic [31:0] fail_pc;
    logic [31:0] fail_exp_pc;
    logic [31:0] commit_cnt;
    logic [31:0] trace_pc;
    logic [2:0]  trace_cnt;

    commit_checker #(
        .TIMEOUT    (TIMEOUT),
        .HALT_REPEAT(HALT_REPEAT),
        .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .commit       (commit),
        .commit_pc    (commit_pc),
        .commit_pre_pc(commit_pre_pc),
        .trace_idx    (trace_idx),
        .state_o      (state_o),
        .done         (done),
        .pass         (pass),
        .fail_pc      (fail_pc),
        .fail_exp_pc  (fail_exp_pc),
        .commit_cnt   (commit_cnt),
        .trace_pc     (trace_pc),
        .trace_cnt    (trace_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  state;
        logic        done;
        logic        pass;
        logic [31:0] cnt;
        logic [2:0]  tcnt;
        logic [31:0] fpc;
        logic [31:0] fexp;
        bit          tvalid;
        logic [31:0] tpc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model: status codes 0..4 = IDLE, RUN, PASS, FAIL, HANG.
    int          m_state = 0;
    logic [31:0] m_exp = '0;
    int          m_halt = 0;
    int          m_idle = 0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_fail_pc = '0;
    logic [31:0] m_fail_exp = '0;
    logic [31:0] m_trace[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit c, input logic [31:0] pc, input logic [31:0] pre);
        if (r) begin
            m_state = 0; m_exp = '0; m_halt = 0; m_idle = 0;
            m_cnt = '0; m_fail_pc = '0; m_fail_exp = '0;
            m_trace.delete();
            return;
        end
        if (m_state >= 2) return;
        if (c) begin
            m_idle = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_trace.push_front(pc);
            if (m_trace.size() > TRACE_DEPTH) void'(m_trace.pop_back());
            if (m_state == 0) begin
                m_exp = pre;
                m_state = 1;
            end else if (pc != m_exp) begin
                m_state = 3;
                m_fail_pc = pc;
                m_fail_exp = m_exp;
            end else begin
                m_exp = pre;
                m_halt = (pc == pre) ? m_halt + 1 : 0;
                if (m_halt == HALT_REPEAT) m_state = 2;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_state = 4;
        end
    endtask

    // Drives one cycle of inputs and queues the state the DUT must show after the next edge.
    task automatic applyStimulus(input bit r, input bit c, input logic [31:0] pc,
                                 input logic [31:0] pre, input logic [1:0] idx);
        exp_t e;
        @(negedge clk);
        rst = r; commit = c; commit_pc = pc; commit_pre_pc = pre; trace_idx = idx;
        modelStep(r, c, pc, pre);
        e.state  = 3'(m_state);
        e.done   = (m_state >= 2);
        e.pass   = (m_state == 2);
        e.cnt    = m_cnt;
        e.tcnt   = 3'(m_trace.size());
        e.fpc    = m_fail_pc;
        e.fexp   = m_fail_exp;
        e.tvalid = (int'(idx) < m_trace.size());
        e.tpc    = e.tvalid ? m_trace[idx] : '0;
        sb.push_back(e);
    endtask

    task automatic idleCycle(input logic [1:0] idx);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, idx);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents registered status; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("state", {29'd0, state_o}, {29'd0, e.state});
                checkOutput("done", {31'd0, done}, {31'd0, e.done});
                checkOutput("pass", {31'd0, pass}, {31'd0, e.pass});
                checkOutput("commit_cnt", commit_cnt, e.cnt);
                checkOutput("trace_cnt", {29'd0, trace_cnt}, {29'd0, e.tcnt});
                checkOutput("fail_pc", fail_pc, e.fpc);
                checkOutput("fail_exp_pc", fail_exp_pc, e.fexp);
                if (e.tvalid) checkOutput("trace_pc", trace_pc, e.tpc);
            end
        end
    end

    initial begin
        bit          r, c;
        int          gap;
        logic [31:0] pc, pre;

        // Reset state
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        afterEdge();
        checkOutput("rst_state", {29'd0, state_o}, 32'd0);
        checkOutput("rst_cnt", commit_cnt, 32'd0);

        // Straight-line chain
        applyStimulus(1'b0, 1'b1, 32'h00, 32'h04, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h04, 32'h08, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h08, 32'h0C, 2'd0);
        afterEdge();
        checkOutput("sl_state", {29'd0, state_o}, 32'd1);
        checkOutput("sl_cnt", commit_cnt, 32'd3);
        checkOutput("sl_trace0", trace_pc, 32'h08);
        checkOutput("sl_tcnt", {29'd0, trace_cnt}, 32'd3);

        // Chain break, then frozen counters
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h14, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h24, 2'd0);
        afterEdge();
        checkOutput("brk_state", {29'd0, state_o}, 32'd3);
        checkOutput("brk_fail_pc", fail_pc, 32'h20);
        checkOutput("brk_fail_exp", fail_exp_pc, 32'h14);
        checkOutput("brk_done", {31'd0, done}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h24, 32'h28, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h28, 32'h2C, 2'd0);
        afterEdge();
        checkOutput("brk_frozen_cnt", commit_cnt, 32'd2);

        // Reset out of FAIL; next commit unchecked
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        afterEdge();
        checkOutput("rrun_state", {29'd0, state_o}, 32'd0);
        checkOutput("rrun_cnt", commit_cnt, 32'd0);
        checkOutput("rrun_tcnt", {29'd0, trace_cnt}, 32'd0);
        checkOutput("rrun_done", {31'd0, done}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h104, 2'd0);
        afterEdge();
        checkOutput("rrun_first", {29'd0, state_o}, 32'd1);

        // Halt loop to PASS
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h44, 2'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h44, 32'h44, 2'd0);
        afterEdge();
        checkOutput("halt3_state", {29'd0, state_o}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h44, 32'h44, 2'd0);
        afterEdge();
        checkOutput("halt4_pass", {31'd0, pass}, 32'd1);
        checkOutput("halt4_cnt", commit_cnt, 32'd5);

        // Interrupted halt loop clears the repeat count
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h44, 2'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h44, 32'h44, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h44, 32'h48, 2'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h48, 32'h48, 2'd0);
        afterEdge();
        checkOutput("hclr_state", {29'd0, state_o}, 32'd1);

        // Hang after the last commit, and the commit-on-last-cycle variant
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h4, 2'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle(2'd0);
        afterEdge();
        checkOutput("hang7_state", {29'd0, state_o}, 32'd1);
        idleCycle(2'd0);
        afterEdge();
        checkOutput("hang8_state", {29'd0, state_o}, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h4, 2'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle(2'd0);
        applyStimulus(1'b0, 1'b1, 32'h4, 32'h8, 2'd0);
        afterEdge();
        checkOutput("hang_saved", {29'd0, state_o}, 32'd1);

        // Hang straight out of reset
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        for (int i = 0; i < TIMEOUT; i++) idleCycle(2'd0);
        afterEdge();
        checkOutput("hang_rst", {29'd0, state_o}, 32'd4);

        // Trace wrap
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 2'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 32'(4 * i), 32'(4 * i + 4), 2'd0);
        afterEdge();
        checkOutput("wrap_tcnt", {29'd0, trace_cnt}, 32'd4);
        checkOutput("wrap_idx0", trace_pc, 32'h14);
        idleCycle(2'd3);
        afterEdge();
        checkOutput("wrap_idx3", trace_pc, 32'h08);

        // Randomized streams
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 99) == 0) || (m_state >= 2 && $urandom_range(0, 3) == 0);
            if (gap > 0) begin
                c = 1'b0;
                gap--;
            end else if ($urandom_range(0, 99) < 3) begin
                c = 1'b0;
                gap = $urandom_range(5, 10);
            end else begin
                c = ($urandom_range(0, 99) < 70);
            end
            if (m_state == 1 && $urandom_range(0, 99) < 95) pc = m_exp;
            else pc = $urandom & 32'h0000_0FFC;
            case ($urandom_range(0, 9))
                0, 1, 2: pre = pc;
                3:       pre = $urandom & 32'h0000_0FFC;
                default: pre = pc + 32'd4;
            endcase
            applyStimulus(r, c, pc, pre, 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
